ana_bellek_yanitlayici: RTL and testbench
=========================================

// Module: ana_bellek_yanitlayici
// PURPOSE
//  Word-granular memory responder sitting on the far side of the veri yolu denetleyici memory port.
//  Accepts pipelined word read/write requests (adres/veri/yaz, gecerli/hazir) and stores words in an internal array.
//  Returns read data in request order over a gecerli/hazir response channel after a fixed latency.
//  Used as the main-memory model in simulation and as on-chip RAM backing in FPGA builds.
// PARAMETERS
//  ADRES_BIT      32    request address width (byte address)
//  VERI_BIT       32    word width; VERI_BYTE = VERI_BIT/8
//  BELLEK_KELIME  1024  array depth in words (power of two)
//  GECIKME        4     read latency in cycles, accept edge to first possible response (>=1)
//  FIFO_DERINLIK  8     response FIFO depth = max outstanding reads (power of two, >=2)
// PORTS
//  clk_i                clk_i  in   1          clock, all logic on rising edge
//  rst_i                rst_i  in   1          asynchronous reset, active-high
//  mem_istek_adres_i    in   ADRES_BIT  request byte address
//  mem_istek_veri_i     in   VERI_BIT   write data
//  mem_istek_yaz_i      in   1          1 = write, 0 = read
//  mem_istek_gecerli_i  in   1          request valid
//  mem_istek_hazir_o    out  1          request ready (registered)
//  mem_veri_o           out  VERI_BIT   read response data (FIFO head)
//  mem_veri_gecerli_o   out  1          response valid
//  mem_veri_hazir_i     in   1          response ready from initiator
// BEHAVIOUR
//  Reset (rst_i=1, async): mem_istek_hazir_o=0, mem_veri_gecerli_o=0, mem_veri_o=0; pipeline, FIFO, kredi cleared.
//   Array contents NOT reset. First rising edge after release sets mem_istek_hazir_o=1.
//  Reset mid-operation: all in-flight and queued reads dropped, no response issued; completed writes retained.
//  Request accept: edge where mem_istek_gecerli_i && mem_istek_hazir_o. At most one request per cycle.
//  Word index = adres[log2(VERI_BYTE) +: log2(BELLEK_KELIME)]; low byte-offset bits and bits above ignored (aliasing).
//  Write: array[index] <= veri at the accept edge; no response generated; no credit consumed.
//  Read: array[index] sampled at the accept edge (sees all writes accepted on earlier edges);
//   word enters a GECIKME-stage valid/data shift pipeline, then pushed into the response FIFO.
//  Latency: read accepted at edge N with empty FIFO -> mem_veri_gecerli_o=1 in the cycle after edge N+GECIKME-1,
//   i.e. GECIKME cycles after accept. Back-to-back reads -> back-to-back responses (1 word/cycle).
//  Response handshake: word popped at edge with mem_veri_gecerli_o && mem_veri_hazir_i; mem_veri_o holds FIFO head
//   and stays stable while gecerli=1 && hazir=0. gecerli = FIFO not empty.
//  Ordering: responses strictly in read-accept order.
//  Credit: kredi = reads in pipeline + FIFO occupancy, width log2(FIFO_DERINLIK)+1.
//   +1 on read accept, -1 on response pop, unchanged if both same edge.
//   mem_istek_hazir_o next = (kredi_next < FIFO_DERINLIK); FIFO can never overflow, pipeline never stalls.
//   Writes are also refused while hazir_o=0 (single ready).
//  FIFO pointers wrap modulo FIFO_DERINLIK; full/empty via extra pointer bit. Push and pop same edge when full
//   cannot occur (credit); push and pop same edge otherwise: occupancy unchanged, head advances.
//  No FSM states beyond reset/run; behaviour is pipeline + FIFO + credit counter.
// TESTING
//  T1 8 writes addr 0x100..0x11C data 0xA0..0xA7, then 8 reads same addrs, hazir_i=1 -> responses 0xA0..0xA7,
//   first gecerli GECIKME=4 cycles after first read accept, then one per cycle.
//  T2 Backpressure: 10 reads, mem_veri_hazir_i=0 -> exactly 8 accepted, mem_istek_hazir_o=0 after 8th;
//   raise hazir_i -> 8 in-order responses, hazir_o returns 1 one cycle after first pop, remaining 2 reads complete.
//  T3 Aliasing: write 0xDEAD to 0x0000_0004, read 0x0000_1004 (BELLEK_KELIME=1024) and 0x0000_0007 -> both 0xDEAD.
//  T4 Write then read same addr on consecutive edges: write 0x55 @0x40, read @0x40 next cycle -> response 0x55.
//  T5 Simultaneous accept+pop at kredi=8 never accepted; at kredi=7: read accept + pop same edge -> kredi stays 7,
//   hazir_o stays 1.
//  T6 Reset mid-burst: 4 reads in flight, assert rst_i async for 2 cycles -> gecerli_o=0 and hazir_o=0 immediately,
//   no stale responses after release; earlier written data still readable.

Source files
------------

// File: rtl/ana_bellek_yanitlayici.sv
// Word memory responder: pipelined read/write requests, in-order read
// responses after a fixed latency, credit-limited response FIFO.
module ana_bellek_yanitlayici #(
   parameter int ADRES_BIT     = 32,
   parameter int VERI_BIT      = 32,
   parameter int BELLEK_KELIME = 1024,
   parameter int GECIKME       = 4,
   parameter int FIFO_DERINLIK = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADRES_BIT-1:0] mem_istek_adres_i,
   input  logic [VERI_BIT-1:0]  mem_istek_veri_i,
   input  logic                 mem_istek_yaz_i,
   input  logic                 mem_istek_gecerli_i,
   output logic                 mem_istek_hazir_o,
   output logic [VERI_BIT-1:0]  mem_veri_o,
   output logic                 mem_veri_gecerli_o,
   input  logic                 mem_veri_hazir_i
);

   localparam int VERI_BYTE = VERI_BIT / 8;
   localparam int OFS       = $clog2(VERI_BYTE);
   localparam int IDX       = $clog2(BELLEK_KELIME);
   localparam int FA        = $clog2(FIFO_DERINLIK);
   localparam int KW        = FA + 1;
   localparam int PD        = (GECIKME > 1) ? GECIKME - 1 : 1;

   logic [VERI_BIT-1:0] dizi [BELLEK_KELIME];
   logic [IDX-1:0]      idx;
   logic                kabul;
   logic                oku_kabul;
   logic                yaz_kabul;
   logic                cek;
   logic                bos;

   logic                hat_v [PD];
   logic [VERI_BIT-1:0] hat_d [PD];
   logic                itme_v;
   logic [VERI_BIT-1:0] itme_d;

   logic [VERI_BIT-1:0] fifo [FIFO_DERINLIK];
   logic [FA:0]         yaz_ptr;
   logic [FA:0]         oku_ptr;

   logic [KW-1:0]       kredi;
   logic [KW-1:0]       kredi_next;

   // Only the word-index bits select storage; the rest alias.
   logic                unused_adres;
   assign unused_adres = ^mem_istek_adres_i;

   assign idx       = mem_istek_adres_i[OFS +: IDX];
   assign kabul     = mem_istek_gecerli_i && mem_istek_hazir_o;
   assign oku_kabul = kabul && !mem_istek_yaz_i;
   assign yaz_kabul = kabul && mem_istek_yaz_i;

   assign bos                = (yaz_ptr == oku_ptr);
   assign mem_veri_gecerli_o = !bos;
   assign cek                = !bos && mem_veri_hazir_i;
   assign mem_veri_o         = bos ? '0 : fifo[oku_ptr[FA-1:0]];

   // Storage array write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (yaz_kabul) dizi[idx] <= mem_istek_veri_i;
   end

   // Read data shift chain; qualified by the valid chain below.
   always_ff @(posedge clk_i) begin
      hat_d[0] <= dizi[idx];
      for (int k = 1; k < PD; k++) hat_d[k] <= hat_d[k-1];
   end

   // Read valid shift chain, flushed by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < PD; k++) hat_v[k] <= 1'b0;
      end else begin
         hat_v[0] <= oku_kabul;
         for (int k = 1; k < PD; k++) hat_v[k] <= hat_v[k-1];
      end
   end

   generate
      if (GECIKME == 1) begin : g_dogrudan
         assign itme_v = oku_kabul;
         assign itme_d = dizi[idx];
      end else begin : g_hat
         assign itme_v = hat_v[GECIKME-2];
         assign itme_d = hat_d[GECIKME-2];
      end
   endgenerate

   // Response FIFO storage; credit guarantees no push while full.
   always_ff @(posedge clk_i) begin
      if (itme_v) fifo[yaz_ptr[FA-1:0]] <= itme_d;
   end

   // FIFO pointers with an extra wrap bit for full/empty.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         yaz_ptr <= '0;
         oku_ptr <= '0;
      end else begin
         if (itme_v) yaz_ptr <= yaz_ptr + 1'b1;
         if (cek)    oku_ptr <= oku_ptr + 1'b1;
      end
   end

   // Outstanding reads: +1 on read accept, -1 on response pop.
   always_comb begin
      kredi_next = kredi;
      unique case ({oku_kabul, cek})
         2'b10:   kredi_next = kredi + KW'(1);
         2'b01:   kredi_next = kredi - KW'(1);
         default: kredi_next = kredi;
      endcase
   end

   // Credit register and registered request ready.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         kredi             <= '0;
         mem_istek_hazir_o <= 1'b0;
      end else begin
         kredi             <= kredi_next;
         mem_istek_hazir_o <= (kredi_next < KW'(FIFO_DERINLIK));
      end
   end

endmodule

// File: tb/tb_ana_bellek_yanitlayici.sv
// Bench for ana_bellek_yanitlayici: queue-based reference model,
// per-cycle output compare, directed scenarios with literal expectations.
module tb_ana_bellek_yanitlayici;

   localparam int GEC = 4;
   localparam int FD  = 8;

   typedef logic [31:0] wq_t [$];
   typedef struct {
      logic [31:0] d;
      int          rdy;
   } bek_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] adres = '0;
   logic [31:0] veri = '0;
   logic        yaz = 1'b0;
   logic        gvalid = 1'b0;
   logic        hazir_o;
   logic [31:0] veri_o;
   logic        gecerli_o;
   logic        hazir_i = 1'b0;

   int          checks = 0;
   int          failures = 0;

   bek_t        q [$];
   logic [31:0] mmem [1024];
   int          cyc = 0;
   bit          m_hazir = 1'b0;
   wq_t         got;
   int          ilk_gecerli = -1;

   ana_bellek_yanitlayici #(
      .ADRES_BIT(32),
      .VERI_BIT(32),
      .BELLEK_KELIME(1024),
      .GECIKME(GEC),
      .FIFO_DERINLIK(FD)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .mem_istek_adres_i(adres),
      .mem_istek_veri_i(veri),
      .mem_istek_yaz_i(yaz),
      .mem_istek_gecerli_i(gvalid),
      .mem_istek_hazir_o(hazir_o),
      .mem_veri_o(veri_o),
      .mem_veri_gecerli_o(gecerli_o),
      .mem_veri_hazir_i(hazir_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   function automatic bit m_gecerli();
      if (q.size() == 0) return 1'b0;
      return q[0].rdy <= cyc;
   endfunction

   // Reference model: queue of outstanding reads with ready times.
   always @(posedge clk or posedge rst) begin : model
      bit p;
      bit a;
      int ix;
      if (rst) begin
         q.delete();
         m_hazir = 1'b0;
      end else begin
         p = hazir_i && m_gecerli();
         a = gvalid && m_hazir;
         if (p) void'(q.pop_front());
         cyc++;
         if (a) begin
            ix = int'((adres >> 2) & 32'h3FF);
            if (yaz) mmem[ix] = veri;
            else q.push_back('{mmem[ix], cyc + GEC - 1});
         end
         m_hazir = q.size() < FD;
      end
   end

   // Per-cycle compare against the model, plus pop capture.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_hazir", 32'(hazir_o), 32'd0);
         chk("rst_gecerli", 32'(gecerli_o), 32'd0);
         chk("rst_veri", veri_o, 32'd0);
      end else begin
         chk("hazir", 32'(hazir_o), 32'(m_hazir));
         chk("gecerli", 32'(gecerli_o), 32'(m_gecerli()));
         if (m_gecerli()) chk("veri", veri_o, q[0].d);
         if (gecerli_o && ilk_gecerli < 0) ilk_gecerli = cyc;
         if (gecerli_o && hazir_i) got.push_back(veri_o);
      end
   end

   task automatic req(input logic [31:0] a, input logic [31:0] d,
                      input logic w, output int acc);
      int n;
      n = 0;
      adres = a;
      veri = d;
      yaz = w;
      gvalid = 1'b1;
      while (!m_hazir && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL req_timeout: got stalled want accept");
      end
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic idle();
      gvalid = 1'b0;
      yaz = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      hazir_i = 1'b1;
      while (q.size() > 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 500) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d left want 0", q.size());
      end
   endtask

   task automatic check_got(input string n, input wq_t exp);
      chk({n, "_count"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         if (i < got.size()) chk(n, got[i], exp[i]);
         else chk(n, 32'hxxxx_xxxx, exp[i]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int t0;
      wq_t e;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hazir", 32'(hazir_o), 32'd0);
      chk("reset_gecerli", 32'(gecerli_o), 32'd0);
      chk("reset_veri", veri_o, 32'd0);
      rst = 1'b0;
      hazir_i = 1'b1;
      @(posedge clk);
      #1;
      chk("release_hazir", 32'(hazir_o), 32'd1);

      // T1: write then read back, latency and throughput
      for (int i = 0; i < 8; i++) req(32'h100 + 4 * i, 32'hA0 + i, 1'b1, t);
      got.delete();
      ilk_gecerli = -1;
      t0 = 0;
      for (int i = 0; i < 8; i++) begin
         req(32'h100 + 4 * i, 32'h0, 1'b0, t);
         if (i == 0) t0 = t;
      end
      idle();
      drain();
      chk("t1_latency", 32'(ilk_gecerli - t0 + 1), 32'd4);
      e = {};
      for (int i = 0; i < 8; i++) e.push_back(32'hA0 + i);
      check_got("t1_data", e);

      // T2: backpressure fills credit, then drains in order
      hazir_i = 1'b0;
      got.delete();
      for (int i = 0; i < 8; i++) req(32'h100 + 4 * i, 32'h0, 1'b0, t);
      chk("t2_hazir_full", 32'(hazir_o), 32'd0);
      adres = 32'h100;
      yaz = 1'b0;
      gvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t2_still_full", 32'(hazir_o), 32'd0);
      chk("t2_head_valid", 32'(gecerli_o), 32'd1);
      hazir_i = 1'b1;
      @(posedge clk);
      #1;
      chk("t2_hazir_back", 32'(hazir_o), 32'd1);
      req(32'h100, 32'h0, 1'b0, t);
      req(32'h104, 32'h0, 1'b0, t);
      idle();
      drain();
      e = {};
      for (int i = 0; i < 8; i++) e.push_back(32'hA0 + i);
      e.push_back(32'hA0);
      e.push_back(32'hA1);
      check_got("t2_data", e);

      // T3: address aliasing
      got.delete();
      req(32'h0000_0004, 32'hDEAD, 1'b1, t);
      req(32'h0000_1004, 32'h0, 1'b0, t);
      req(32'h0000_0007, 32'h0, 1'b0, t);
      idle();
      drain();
      check_got("t3_alias", '{32'hDEAD, 32'hDEAD});

      // T4: read right after write to same word
      got.delete();
      req(32'h40, 32'h55, 1'b1, t);
      req(32'h40, 32'h0, 1'b0, t);
      idle();
      drain();
      check_got("t4_raw", '{32'h55});

      // T5: accept and pop on the same edge at seven outstanding
      hazir_i = 1'b0;
      got.delete();
      for (int i = 0; i < 7; i++) req(32'h100 + 4 * i, 32'h0, 1'b0, t);
      idle();
      repeat (6) @(posedge clk);
      #1;
      chk("t5_hazir_at7", 32'(hazir_o), 32'd1);
      hazir_i = 1'b1;
      req(32'h11C, 32'h0, 1'b0, t);
      hazir_i = 1'b0;
      chk("t5_hazir_stays", 32'(hazir_o), 32'd1);
      @(posedge clk);
      #1;
      chk("t5_hazir_at8", 32'(hazir_o), 32'd0);
      idle();
      drain();
      e = {};
      for (int i = 0; i < 8; i++) e.push_back(32'hA0 + i);
      e.push_back(32'hA7);
      check_got("t5_data", e);

      // T6: asynchronous reset with reads in flight
      got.delete();
      for (int i = 0; i < 4; i++) req(32'h100 + 4 * i, 32'h0, 1'b0, t);
      idle();
      chk("t6_pre_gecerli", 32'(gecerli_o), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_async_gecerli", 32'(gecerli_o), 32'd0);
      chk("t6_async_hazir", 32'(hazir_o), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("t6_no_stale", 32'(got.size()), 32'd0);
      req(32'h100, 32'h0, 1'b0, t);
      req(32'h11C, 32'h0, 1'b0, t);
      idle();
      drain();
      check_got("t6_retained", '{32'hA0, 32'hA7});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
